// File: rtl/apb_gpio_if.sv
`default_nettype none
// ---------------------------------------------------------------
// apb_gpio_if : APB completer bus bundle for apb_gpio.   Rev 1.0
// ---------------------------------------------------------------
interface apb_gpio_if #(
    parameter int AddrWidth = 32
);
    logic                 psel_i;
    logic                 penable_i;
    logic                 pwrite_i;
    logic [AddrWidth-1:0] paddr_i;
    logic [31:0]          pwdata_i;
    logic [31:0]          prdata_o;
    logic                 pready_o;
    logic                 pslverr_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface
`default_nettype wire

// File: rtl/apb_gpio.sv
`default_nettype none
// ---------------------------------------------------------------
// apb_gpio : APB GPIO with edge-detect W1C interrupts.   Rev 1.0
// ---------------------------------------------------------------
module apb_gpio #(
    parameter int NrPins    = 8,
    parameter int AddrWidth = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    apb_gpio_if.slave         apb,
    input  logic [NrPins-1:0] gpio_i,
    output logic [NrPins-1:0] gpio_o,
    output logic [NrPins-1:0] gpio_oe_o,
    output logic              irq_o
);
    localparam logic [2:0] OFF_DIR     = 3'd0;
    localparam logic [2:0] OFF_OUT     = 3'd1;
    localparam logic [2:0] OFF_IN      = 3'd2;
    localparam logic [2:0] OFF_RISE_EN = 3'd3;
    localparam logic [2:0] OFF_FALL_EN = 3'd4;
    localparam logic [2:0] OFF_PENDING = 3'd5;
    localparam logic [2:0] OFF_TOGGLE  = 3'd6;
    localparam logic [2:0] OFF_RSVD    = 3'd7;

    logic [AddrWidth-1:0] addr;
    logic [2:0]           offset;
    logic [NrPins-1:0]    wdata;
    logic                 access;
    logic                 bus_err;
    logic                 wr_en;
    logic                 unused_bits;

    logic [NrPins-1:0] dir_q, out_q, rise_en_q, fall_en_q, pending_q;
    logic [NrPins-1:0] sync1_q, in_q, prev_q;
    logic [NrPins-1:0] rise, fall, clr_mask, pending_next;
    logic [NrPins-1:0] rd_sel;

    assign addr        = apb.paddr_i;
    assign offset      = addr[4:2];
    assign wdata       = apb.pwdata_i[NrPins-1:0];
    assign unused_bits = ^{addr, apb.pwdata_i};

    // Errors are flagged only in the access phase and suppress the commit.
    assign access  = apb.psel_i & apb.penable_i;
    assign bus_err = access & ((offset == OFF_RSVD) | (apb.pwrite_i & (offset == OFF_IN)));
    assign wr_en   = access & apb.pwrite_i & ~bus_err;

    assign apb.pready_o  = apb.psel_i;
    assign apb.pslverr_o = bus_err;

    assign rise     = in_q & ~prev_q & rise_en_q;
    assign fall     = ~in_q & prev_q & fall_en_q;
    assign clr_mask = (wr_en && offset == OFF_PENDING) ? wdata : '0;
    // OR-ing the new edges after the clear makes a same-cycle set win.
    assign pending_next = (pending_q & ~clr_mask) | rise | fall;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pending_q <= '0;
            sync1_q   <= '0;
            in_q      <= '0;
            prev_q    <= '0;
        end else begin
            sync1_q   <= gpio_i;
            in_q      <= sync1_q;
            prev_q    <= in_q;
            pending_q <= pending_next;
            if (wr_en) begin
                case (offset)
                    OFF_DIR:     dir_q     <= wdata;
                    OFF_OUT:     out_q     <= wdata;
                    OFF_RISE_EN: rise_en_q <= wdata;
                    OFF_FALL_EN: fall_en_q <= wdata;
                    OFF_TOGGLE:  out_q     <= out_q ^ wdata;
                    default:     ;
                endcase
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        if (apb.psel_i && !apb.pwrite_i) begin
            case (offset)
                OFF_DIR:     rd_sel = dir_q;
                OFF_OUT:     rd_sel = out_q;
                OFF_IN:      rd_sel = in_q;
                OFF_RISE_EN: rd_sel = rise_en_q;
                OFF_FALL_EN: rd_sel = fall_en_q;
                OFF_PENDING: rd_sel = pending_q;
                default:     rd_sel = '0;
            endcase
        end
    end

    assign apb.prdata_o = 32'(rd_sel);
    assign gpio_o       = out_q;
    assign gpio_oe_o    = dir_q;
    assign irq_o        = |pending_q;
endmodule
`default_nettype wire

// File: tb/tb_apb_gpio.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_apb_gpio : scoreboard-driven self-checking bench.   Rev 1.0
// ---------------------------------------------------------------
module tb_apb_gpio;
    localparam int NP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] gpio_in;
    logic [NP-1:0] gpio_out;
    logic [NP-1:0] gpio_oe;
    logic          irq;

    apb_gpio_if #(.AddrWidth(32)) bus ();

    apb_gpio #(.NrPins(NP), .AddrWidth(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .apb       (bus),
        .gpio_i    (gpio_in),
        .gpio_o    (gpio_out),
        .gpio_oe_o (gpio_oe),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", got, 32'hDEAD_BEEF);
        end else begin
            e = sb.pop_front();
            chk(e.tag, got, e.val);
        end
    endtask

    task automatic check_pins(input logic [NP-1:0] oe, input logic [NP-1:0] out, input logic irq_exp);
        sb_push("gpio_oe", 32'(oe));
        sb_push("gpio_o", 32'(out));
        sb_push("irq", 32'(irq_exp));
        @(negedge clk);
        sb_pop(32'(gpio_oe));
        sb_pop(32'(gpio_out));
        sb_pop(32'(irq));
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, input logic err);
        @(posedge clk); #1;
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b1;
        bus.paddr_i   = addr;
        bus.pwdata_i  = data;
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
        sb_push($sformatf("wr%02h pready", addr[7:0]), 32'd1);
        sb_push($sformatf("wr%02h pslverr", addr[7:0]), 32'(err));
        @(negedge clk);
        sb_pop(32'(bus.pready_o));
        sb_pop(32'(bus.pslverr_o));
        @(posedge clk); #1;
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input logic err);
        @(posedge clk); #1;
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
        bus.paddr_i   = addr;
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
        sb_push($sformatf("rd%02h prdata", addr[7:0]), exp);
        sb_push($sformatf("rd%02h pready", addr[7:0]), 32'd1);
        sb_push($sformatf("rd%02h pslverr", addr[7:0]), 32'(err));
        @(negedge clk);
        sb_pop(bus.prdata_o);
        sb_pop(32'(bus.pready_o));
        sb_pop(32'(bus.pslverr_o));
        @(posedge clk); #1;
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
        bus.paddr_i   = '0;
        bus.pwdata_i  = '0;
        gpio_in       = 8'h80;

        // Reset state with the bus idle.
        repeat (2) @(posedge clk);
        check_pins(8'h00, 8'h00, 1'b0);
        sb_push("idle prdata", 32'd0);
        sb_push("idle pready", 32'd0);
        sb_push("idle pslverr", 32'd0);
        @(negedge clk);
        sb_pop(bus.prdata_o);
        sb_pop(32'(bus.pready_o));
        sb_pop(32'(bus.pslverr_o));
        rst = 1'b0;
        repeat (4) @(posedge clk);
        apb_read(32'h14, 32'h00, 1'b0);
        apb_read(32'h08, 32'h80, 1'b0);

        // Direction / output registers.
        apb_write(32'h00, 32'h0F, 1'b0);
        apb_write(32'h04, 32'hA5, 1'b0);
        check_pins(8'h0F, 8'hA5, 1'b0);
        apb_read(32'h00, 32'h0F, 1'b0);
        apb_read(32'h04, 32'hA5, 1'b0);

        // Toggle, and upper bits ignored.
        apb_write(32'h18, 32'hFF, 1'b0);
        check_pins(8'h0F, 8'h5A, 1'b0);
        apb_read(32'h18, 32'h00, 1'b0);
        apb_write(32'h00, 32'hFFFF_FF3C, 1'b0);
        apb_read(32'h00, 32'h3C, 1'b0);

        // Rising edge on pin 0: pending two edges after the pin settles.
        apb_write(32'h0C, 32'h01, 1'b0);
        gpio_in[0] = 1'b1;
        @(posedge clk);
        check_pins(8'h3C, 8'h5A, 1'b0);
        @(posedge clk);
        check_pins(8'h3C, 8'h5A, 1'b0);
        @(posedge clk);
        check_pins(8'h3C, 8'h5A, 1'b1);
        apb_read(32'h14, 32'h01, 1'b0);
        apb_write(32'h14, 32'h01, 1'b0);
        check_pins(8'h3C, 8'h5A, 1'b0);

        // Falling edge on pin 7 lands on the same edge as a clear of bit 7.
        apb_write(32'h10, 32'h80, 1'b0);
        gpio_in[7] = 1'b0;
        apb_write(32'h14, 32'h80, 1'b0);
        apb_read(32'h14, 32'h80, 1'b0);
        apb_write(32'h10, 32'h00, 1'b0);
        apb_read(32'h14, 32'h80, 1'b0);
        apb_write(32'h14, 32'h80, 1'b0);
        check_pins(8'h3C, 8'h5A, 1'b0);

        // Error responses leave state alone.
        apb_read(32'h1C, 32'h00, 1'b1);
        apb_write(32'h08, 32'hFF, 1'b1);
        apb_read(32'h08, 32'h01, 1'b0);

        // Two-clock pulse on pin 1 is caught.
        gpio_in = 8'h00;
        apb_write(32'h0C, 32'h02, 1'b0);
        repeat (4) @(posedge clk);
        #1 gpio_in[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1 gpio_in[1] = 1'b0;
        repeat (4) @(posedge clk);
        apb_read(32'h14, 32'h02, 1'b0);

        // Fill PENDING and OUT, then reset in the middle of a transfer.
        apb_write(32'h0C, 32'hFF, 1'b0);
        gpio_in = 8'hFF;
        repeat (4) @(posedge clk);
        apb_read(32'h14, 32'hFF, 1'b0);
        apb_write(32'h04, 32'hFF, 1'b0);
        apb_write(32'h00, 32'hFF, 1'b0);
        check_pins(8'hFF, 8'hFF, 1'b1);

        @(posedge clk); #1;
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b1;
        bus.paddr_i   = 32'h04;
        bus.pwdata_i  = 32'h0F;
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        sb_push("rst gpio_oe", 32'd0);
        sb_push("rst gpio_o", 32'd0);
        sb_push("rst irq", 32'd0);
        #1;
        sb_pop(32'(gpio_oe));
        sb_pop(32'(gpio_out));
        sb_pop(32'(irq));
        #1;
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        apb_read(32'h14, 32'h00, 1'b0);
        apb_read(32'h04, 32'h00, 1'b0);
        apb_read(32'h0C, 32'h00, 1'b0);
        check_pins(8'h00, 8'h00, 1'b0);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/apb_gpio.md
APB_GPIO -- requirements
Module: apb_gpio

Interface
REQ-001 SHALL have parameter NrPins, default 8, number of GPIO pins; legal range 1..32.
REQ-002 SHALL have parameter AddrWidth, default 32, APB address width.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 psel_i  input  1  APB select.
REQ-007 penable_i  input  1  APB access phase.
REQ-008 pwrite_i  input  1  1 = write, 0 = read.
REQ-009 paddr_i  input  AddrWidth  byte address; only bits [4:2] decoded.
REQ-010 pwdata_i  input  32  write data.
REQ-011 prdata_o  output  32  read data.
REQ-012 pready_o  output  1  transfer complete.
REQ-013 pslverr_o  output  1  transfer error.
REQ-014 gpio_i  input  NrPins  asynchronous pin inputs.
REQ-015 gpio_o  output  NrPins  pin output values.
REQ-016 gpio_oe_o  output  NrPins  output enables, 1 = drive.
REQ-017 irq_o  output  1  level interrupt to the interrupt controller.

Function
REQ-018 SHALL decode word offsets: 0x00 DIR (RW), 0x04 OUT (RW), 0x08 IN (RO), 0x0C RISE_EN (RW), 0x10 FALL_EN (RW), 0x14 PENDING (W1C), 0x18 TOGGLE (WO, reads 0), 0x1C reserved.
REQ-019 SHALL drive pready_o = 1 whenever psel_i = 1 (zero wait states), 0 otherwise.
REQ-020 SHALL commit writes only on the rising edge where psel_i & penable_i & pwrite_i = 1.
REQ-021 SHALL drive prdata_o combinationally from the addressed register when psel_i & ~pwrite_i, else 0.
REQ-022 SHALL assert pslverr_o in the access phase for offset 0x1C or a write to IN; no state change on error.
REQ-023 SHALL read bits [31:NrPins] of every register as 0 and ignore writes to them.
REQ-024 SHALL drive gpio_oe_o = DIR and gpio_o = OUT directly from the registers.
REQ-025 TOGGLE write SHALL set OUT <= OUT ^ pwdata_i[NrPins-1:0] in the same commit edge.
REQ-026 SHALL synchronise gpio_i through a 2-flop synchroniser; IN reads the second flop.
REQ-027 SHALL hold a prev register equal to IN delayed one cycle.
REQ-028 Per pin: rise = IN & ~prev & RISE_EN, fall = ~IN & prev & FALL_EN; either sets PENDING bit on the next edge.
REQ-029 Latency: pin transition settled before edge 0 is visible in IN after edge 1 and in PENDING after edge 2; irq_o in the same cycle as PENDING.
REQ-030 PENDING write SHALL clear bits where pwdata_i = 1; when a new edge and a clear hit the same bit in one cycle, set wins.
REQ-031 irq_o SHALL equal OR-reduce of PENDING (combinational from the register).
REQ-032 Clearing RISE_EN/FALL_EN SHALL NOT clear already-pending bits.
REQ-033 Pulses shorter than one clock MAY be missed; pulses of at least 2 clocks SHALL be detected.

Reset
REQ-034 rst_i SHALL clear DIR, OUT, RISE_EN, FALL_EN, PENDING, synchroniser and prev registers to 0 asynchronously.
REQ-035 During and after reset: gpio_o = 0, gpio_oe_o = 0, irq_o = 0; prdata_o, pready_o, pslverr_o = 0 while psel_i = 0.
REQ-036 Reset mid-transfer SHALL abort it with no register update; pins high at reset release SHALL NOT raise PENDING because enables are 0.

Verification
REQ-037 Write DIR = 0x0F, OUT = 0xA5 -> gpio_oe_o = 0x0F, gpio_o = 0xA5; readback matches; pready_o = 1, pslverr_o = 0.
REQ-038 TOGGLE write 0xFF after OUT = 0xA5 -> gpio_o = 0x5A next cycle; TOGGLE read returns 0.
REQ-039 RISE_EN = 0x01, gpio_i[0] 0->1 -> PENDING = 0x01 and irq_o = 1 exactly 2 edges later; PENDING write 0x01 -> irq_o = 0.
REQ-040 FALL_EN = 0x80, gpio_i[7] 1->0 coinciding with a PENDING write 0x80 -> bit 7 remains set (set wins).
REQ-041 Read 0x1C or write 0x08 -> pslverr_o = 1, prdata_o = 0, IN unchanged.
REQ-042 Assert rst_i with PENDING = 0xFF, OUT = 0xFF -> irq_o, gpio_o, gpio_oe_o = 0 immediately, before the next clock edge.
